// File: rtl/food_placer.sv
// food_placer: draws a random interior playfield cell from a free-running LFSR and
// rejects cells under the snake. Optional retry cap: define FOOD_PLACER_ATTEMPT_LIMIT_EN.
module food_placer #(
    parameter int          GRID_HEIGHT = 30,
    parameter int          GRID_WIDTH  = 40,
    parameter int          NUM_PIECES  = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          FOOD_INIT_Y = 5,
    parameter int          FOOD_INIT_X = 10,
    localparam int         YB          = $clog2(GRID_HEIGHT),
    localparam int         XB          = $clog2(GRID_WIDTH)
) (
    input  logic                     Clock,
    input  logic                     ResetN,
    input  logic                     Request,
    input  logic [YB*NUM_PIECES-1:0] PackSnakeY,
    input  logic [XB*NUM_PIECES-1:0] PackSnakeX,
    output logic [YB-1:0]            FoodY,
    output logic [XB-1:0]            FoodX,
    output logic                     Valid,
    output logic                     Busy
);

    // state | meaning
    // IDLE  | waiting for Request; snake snapshot taken on acceptance
    // DRAW  | testing the current LFSR value as an interior candidate
    // SCAN  | comparing the candidate against one snapshot segment per cycle
    // DONE  | food updated, Valid high for this single cycle
    typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_SCAN, ST_DONE} state_t;

    localparam int            IB       = (NUM_PIECES > 1) ? $clog2(NUM_PIECES) : 1;
    localparam logic [IB-1:0] IDX_LAST = IB'(NUM_PIECES - 1);
    localparam logic [YB-1:0] Y_MAX    = YB'(GRID_HEIGHT - 2);
    localparam logic [XB-1:0] X_MAX    = XB'(GRID_WIDTH - 2);

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [YB-1:0] snap_y_q [NUM_PIECES];
    logic [YB-1:0] snap_y_d [NUM_PIECES];
    logic [XB-1:0] snap_x_q [NUM_PIECES];
    logic [XB-1:0] snap_x_d [NUM_PIECES];
    logic [IB-1:0] idx_q, idx_d;
    logic [YB-1:0] cand_y_q, cand_y_d;
    logic [XB-1:0] cand_x_q, cand_x_d;
    logic [YB-1:0] food_y_q, food_y_d;
    logic [XB-1:0] food_x_q, food_x_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
    logic [5:0]    attempt_q, attempt_d;
`endif

    logic [YB-1:0] draw_y;
    logic [XB-1:0] draw_x;
    logic          draw_ok;
    logic          seg_hit;

    assign draw_y  = lfsr_q[YB-1:0];
    assign draw_x  = lfsr_q[YB+XB-1:YB];
    // Border cells are never legal, so (0,0) empty slots can never be hit.
    assign draw_ok = (draw_y != '0) && (draw_y <= Y_MAX) &&
                     (draw_x != '0) && (draw_x <= X_MAX);
    assign seg_hit = (snap_y_q[idx_q] == cand_y_q) && (snap_x_q[idx_q] == cand_x_q);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        snap_y_d = snap_y_q;
        snap_x_d = snap_x_q;
        idx_d    = idx_q;
        cand_y_d = cand_y_q;
        cand_x_d = cand_x_q;
        food_y_d = food_y_q;
        food_x_d = food_x_q;
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
        attempt_d = attempt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Request) begin
                    for (int h = 0; h < NUM_PIECES; h++) begin
                        snap_y_d[h] = PackSnakeY[h*YB +: YB];
                        snap_x_d[h] = PackSnakeX[h*XB +: XB];
                    end
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
                    attempt_d = '0;
`endif
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (draw_ok) begin
                    cand_y_d = draw_y;
                    cand_x_d = draw_x;
                    idx_d    = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (seg_hit) begin
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
                    attempt_d = attempt_q + 6'd1;
                    state_d   = (attempt_q == 6'd63) ? ST_IDLE : ST_DRAW;
`else
                    state_d   = ST_DRAW;
`endif
                end else if (idx_q == IDX_LAST) begin
                    food_y_d = cand_y_q;
                    food_x_d = cand_x_q;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + IB'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            snap_y_q  <= '{default: '0};
            snap_x_q  <= '{default: '0};
            idx_q     <= '0;
            cand_y_q  <= '0;
            cand_x_q  <= '0;
            food_y_q  <= YB'(FOOD_INIT_Y);
            food_x_q  <= XB'(FOOD_INIT_X);
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
            attempt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            snap_y_q  <= snap_y_d;
            snap_x_q  <= snap_x_d;
            idx_q     <= idx_d;
            cand_y_q  <= cand_y_d;
            cand_x_q  <= cand_x_d;
            food_y_q  <= food_y_d;
            food_x_q  <= food_x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
            attempt_q <= attempt_d;
`endif
        end
    end

    assign FoodY = food_y_q;
    assign FoodX = food_x_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: transaction-level reference model driven by a table of
// directed vectors, hand-written hold/reset sequences and randomized snakes.
module tb_food_placer;
    localparam int          GH     = 30;
    localparam int          GW     = 40;
    localparam int          NP     = 16;
    localparam int          YB     = 5;
    localparam int          XB     = 6;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          INIT_Y = 5;
    localparam int          INIT_X = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic [YB*NP-1:0]  pack_y;
    logic [XB*NP-1:0]  pack_x;
    logic [YB-1:0]     food_y;
    logic [XB-1:0]     food_x;
    logic              valid;
    logic              busy;

    food_placer #(
        .GRID_HEIGHT(GH), .GRID_WIDTH(GW), .NUM_PIECES(NP),
        .LFSR_SEED(SEED), .FOOD_INIT_Y(INIT_Y), .FOOD_INIT_X(INIT_X)
    ) dut (
        .Clock(clk), .ResetN(rst_n), .Request(req),
        .PackSnakeY(pack_y), .PackSnakeX(pack_x),
        .FoodY(food_y), .FoodX(food_x), .Valid(valid), .Busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR: free-running since the last reset release.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lstep(m_lfsr);

    int total = 0;
    int bad   = 0;
    int seg_y [NP];
    int seg_x [NP];
    int snap_y[NP];
    int snap_x[NP];
    int exp_fy = INIT_Y;
    int exp_fx = INIT_X;

    typedef struct {
        int gap;
        int nseg;
        int plant;
        bit scramble;
        int exp_valids;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit interior(input int y, input int x);
        return (y >= 1) && (y <= GH - 2) && (x >= 1) && (x <= GW - 2);
    endfunction

    task automatic drive_pack();
        for (int h = 0; h < NP; h++) begin
            pack_y[h*YB +: YB] = YB'(seg_y[h]);
            pack_x[h*XB +: XB] = XB'(seg_x[h]);
        end
    endtask

    task automatic set_snake(input int nseg);
        for (int h = 0; h < NP; h++) begin
            seg_y[h] = (h < nseg) ? int'($urandom_range(GH - 2, 1)) : 0;
            seg_x[h] = (h < nseg) ? int'($urandom_range(GW - 2, 1)) : 0;
        end
    endtask

    // First interior cell the LFSR yields after the request edge, and its edge offset.
    task automatic first_draw(input logic [15:0] l0, output int y, output int x, output int e);
        logic [15:0] l;
        l = lstep(l0);
        e = 1;
        y = 0;
        x = 0;
        for (int i = 0; i < 65536; i++) begin
            y = int'(l[YB-1:0]);
            x = int'(l[YB+XB-1:YB]);
            if (interior(y, x)) return;
            l = lstep(l);
            e++;
        end
    endtask

    // Transaction model: l0 is the LFSR value seen at the request edge. n is the number
    // of edges after the request edge until Valid is visible (or until IDLE on a cap).
    task automatic model(input logic [15:0] l0, output int ey, output int ex,
                         output int n, output bit lim);
        logic [15:0] l;
        int y, x, e, m, att;
        l = lstep(l0);
        e = 1; att = 0; lim = 1'b0; n = -1; ey = exp_fy; ex = exp_fx;
        for (int it = 0; it < 100000 && n < 0; it++) begin
            y = int'(l[YB-1:0]);
            x = int'(l[YB+XB-1:YB]);
            if (!interior(y, x)) begin
                l = lstep(l);
                e++;
            end else begin
                m = -1;
                for (int h = 0; h < NP; h++)
                    if (m < 0 && snap_y[h] == y && snap_x[h] == x) m = h;
                if (m < 0) begin
                    ey = y; ex = x; n = e + NP;
                end else begin
                    att++;
`ifdef FOOD_PLACER_ATTEMPT_LIMIT_EN
                    if (att == 64) begin lim = 1'b1; n = e + m + 1; end
`endif
                    for (int s = 0; s < m + 2; s++) l = lstep(l);
                    e += m + 2;
                end
            end
        end
    endtask

    // Entered and left at #1 after an edge with the DUT in IDLE.
    task automatic do_txn(input bit hold, input bit scramble, input int plant,
                          input bit noise, output int vcnt);
        logic [15:0] l0;
        int ey, ex, n, nend, vat, berr, py, px, pe, on_snake;
        bit lim;
        l0 = m_lfsr;
        py = -1; px = -1;
        if (plant >= 0) begin
            first_draw(l0, py, px, pe);
            seg_y[plant] = py;
            seg_x[plant] = px;
        end
        drive_pack();
        snap_y = seg_y;
        snap_x = seg_x;
        req = 1'b1;
        model(l0, ey, ex, n, lim);
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        if (scramble) begin
            for (int h = 0; h < NP; h++) begin seg_y[h] = ey; seg_x[h] = ex; end
            drive_pack();
        end
        vcnt = 0; vat = -1; berr = 0;
        if (n < 0) begin
            chk("model_bound", n, 0);
            return;
        end
        nend = lim ? n : n + 1;
        for (int c = 0; c <= nend; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (valid) begin vcnt++; if (vat < 0) vat = c; end
            if (busy !== (c < nend)) berr++;
            if (noise && !hold) req = (c < nend) ? 1'($urandom_range(1, 0)) : 1'b0;
        end
        chk("valid_cycle", vat, lim ? -1 : n);
        chk("busy_window", berr, 0);
        if (!lim) begin exp_fy = ey; exp_fx = ex; end
        chk("food_y", int'(food_y), exp_fy);
        chk("food_x", int'(food_x), exp_fx);
        if (!lim) begin
            on_snake = 0;
            for (int h = 0; h < NP; h++)
                if (snap_y[h] == int'(food_y) && snap_x[h] == int'(food_x)) on_snake = 1;
            chk("food_interior", int'(interior(int'(food_y), int'(food_x))), 1);
            chk("food_off_snake", on_snake, 0);
            if (plant >= 0) begin
                chk("food_moved", int'(int'(food_y) == py && int'(food_x) == px), 0);
                chk("retry_latency", int'(vat > NP + 1), 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc, idle_err, gap, nseg, plant, py, px, pe;
        bit scr;

        vecs[0] = '{0, 0, -1, 1'b0, 1};   // empty snake
        vecs[1] = '{2, 0, 3, 1'b0, 1};    // lone segment 3 sits on the first draw
        vecs[2] = '{1, 16, 3, 1'b0, 1};   // full snake plus forced collision
        vecs[3] = '{0, 16, 15, 1'b1, 1};  // pack inputs rewritten mid-scan
        vecs[4] = '{3, 8, 0, 1'b0, 1};    // collision on the very first compare

        rst_n = 1'b0;
        req   = 1'b0;
        set_snake(0);
        drive_pack();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_food_y", int'(food_y), INIT_Y);
        chk("rst_food_x", int'(food_x), INIT_X);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        idle_err = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid || busy) idle_err++;
        end
        chk("idle_quiet", idle_err, 0);

        foreach (vecs[i]) begin
            idle_err = 0;
            for (int g = 0; g < vecs[i].gap; g++) begin
                @(posedge clk); #1;
                if (valid || busy) idle_err++;
            end
            chk("gap_quiet", idle_err, 0);
            set_snake(vecs[i].nseg);
            do_txn(1'b0, vecs[i].scramble, vecs[i].plant, 1'b1, vc);
            chk("vec_valids", vc, vecs[i].exp_valids);
        end

        // Request held high: one Valid per IDLE visit, Busy low between visits.
        set_snake(6);
        for (int t = 0; t < 3; t++) begin
            do_txn(1'b1, t == 1, -1, 1'b0, vc);
            chk("hold_valids", vc, 1);
            chk("hold_idle_busy", int'(busy), 0);
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("hold_release_busy", int'(busy), 0);

        // Reset while SCAN is on index 5.
        set_snake(0);
        drive_pack();
        first_draw(m_lfsr, py, px, pe);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (pe + 5) @(posedge clk);
        #1;
        chk("scan_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_food_y", int'(food_y), INIT_Y);
        chk("midrst_food_x", int'(food_x), INIT_X);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_fy = INIT_Y;
        exp_fx = INIT_X;
        vc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid || busy) vc++;
        end
        chk("post_rst_quiet", vc, 0);

        for (int r = 0; r < 12; r++) begin
            gap   = int'($urandom_range(3, 0));
            nseg  = int'($urandom_range(NP, 0));
            plant = ($urandom_range(1, 0) == 1) ? int'($urandom_range(NP - 1, 0)) : -1;
            scr   = ($urandom_range(3, 0) == 0);
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
            set_snake(nseg);
            do_txn(1'b0, scr, plant, 1'b1, vc);
            chk("rand_valids", vc, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
